// File: rtl/cache_memory.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines of 16 bytes.
// Misses stall the CPU, write back a dirty victim, then refill over the
// memory-side busywait handshake.
module cache_memory (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         read,
   input  logic         write,
   input  logic [31:0]  address,
   input  logic [31:0]  writedata,
   output logic [31:0]  readdata,
   output logic         busywait,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_address,
   output logic [127:0] mem_writedata,
   input  logic [127:0] mem_readdata,
   input  logic         mem_busywait,
   input  logic         inst_hit
);

   typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_READ, UPDATE} state_t;

   state_t       state;
   logic         first;       // first cycle of a memory state: mem_busywait ignored
   logic [7:0]   valid;
   logic [7:0]   dirty;
   logic [24:0]  tag_arr  [8];
   logic [127:0] data_arr [8];
   logic [127:0] fill_buf;    // refill block captured at the completing edge
   logic [31:0]  rd_q;        // last delivered load word

   logic [24:0]  tag_in;
   logic [2:0]   index;
   logic [1:0]   word;
   logic [6:0]   woff;
   logic         req, hit, idle, rd_hit, wr_hit, done;
   logic [127:0] line;
   logic [31:0]  sel_word;
   logic         unused_ok;

   assign tag_in    = address[31:7];
   assign index     = address[6:4];
   assign word      = address[3:2];
   assign woff      = {word, 5'b0};
   assign unused_ok = ^address[1:0];

   assign req      = (read | write) & inst_hit;
   assign hit      = valid[index] && (tag_arr[index] == tag_in);
   assign idle     = (state == IDLE);
   assign rd_hit   = idle & req & hit & ~write;
   assign wr_hit   = idle & req & hit & write;
   assign line     = data_arr[index];
   assign sel_word = line[woff +: 32];
   assign done     = ~first & ~mem_busywait;

   // Stall whenever a transfer is in progress or a fresh request misses; held low in reset
   always_comb begin
      busywait = ~RESET & (~idle | (req & ~hit));
   end

   // Load data is live on a read hit, otherwise the last delivered word
   always_comb begin
      readdata = rd_hit ? sel_word : rd_q;
   end

   // Memory-side address/data track the current transfer state
   always_comb begin
      mem_address   = 28'd0;
      mem_writedata = 128'd0;
      case (state)
         WRITE_BACK: begin
            mem_address   = {tag_arr[index], index};
            mem_writedata = line;
         end
         MEM_READ: mem_address = address[31:4];
         default: ;
      endcase
   end

   // Miss-handling FSM with registered memory requests and line status bits
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         first     <= 1'b0;
         valid     <= '0;
         dirty     <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         rd_q      <= 32'd0;
         fill_buf  <= 128'd0;
      end else begin
         first <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_hit) rd_q <= sel_word;
               if (wr_hit) dirty[index] <= 1'b1;
               else if (req & ~hit) begin
                  first <= 1'b1;
                  if (valid[index] & dirty[index]) begin
                     state     <= WRITE_BACK;
                     mem_write <= 1'b1;
                  end else begin
                     state    <= MEM_READ;
                     mem_read <= 1'b1;
                  end
               end
            end
            WRITE_BACK: begin
               if (done) begin
                  state     <= MEM_READ;
                  mem_write <= 1'b0;
                  mem_read  <= 1'b1;
                  first     <= 1'b1;
               end
            end
            MEM_READ: begin
               if (done) begin
                  state    <= UPDATE;
                  mem_read <= 1'b0;
                  fill_buf <= mem_readdata;
               end
            end
            UPDATE: begin
               valid[index] <= 1'b1;
               dirty[index] <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Tag/data arrays: store-hit word writes and refill installs
   always_ff @(posedge CLK) begin
      if (wr_hit) data_arr[index][woff +: 32] <= writedata;
      if (state == UPDATE) begin
         data_arr[index] <= fill_buf;
         tag_arr[index]  <= tag_in;
      end
   end

endmodule

// File: tb/tb_cache_memory.sv
// Directed bench for cache_memory with a small busywait memory model.
module tb_cache_memory;

   logic         CLK = 1'b0;
   logic         RESET;
   logic         read, write, inst_hit;
   logic [31:0]  address, writedata, readdata;
   logic         busywait, mem_read, mem_write, mem_busywait;
   logic [27:0]  mem_address;
   logic [127:0] mem_writedata, mem_readdata;

   int checks = 0;
   int errors = 0;
   int memops = 0;
   bit both_seen = 1'b0;

   cache_memory dut (
      .CLK(CLK), .RESET(RESET), .read(read), .write(write), .address(address),
      .writedata(writedata), .readdata(readdata), .busywait(busywait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
      .mem_busywait(mem_busywait), .inst_hit(inst_hit)
   );

   always #5 CLK = ~CLK;

   // memory model: default block pattern per address, overridden by write-backs
   bit [63:0]  wflag;
   bit [127:0] wdat [0:63];
   int         cnt = 0;
   int         lat = 2;
   logic [1:0] last = 2'b00;
   logic [1:0] mreq;

   function automatic logic [127:0] dflt(input logic [27:0] a);
      if (a == 28'h4) return 128'h44444444_33333333_22222222_11111111;
      return {4'h3, a, 4'h2, a, 4'h1, a, 4'h0, a};
   endfunction

   assign mreq         = {mem_read, mem_write};
   assign mem_busywait = (mreq != 2'b00) && (cnt < lat);
   assign mem_readdata = wflag[mem_address[5:0]] ? wdat[mem_address[5:0]] : dflt(mem_address);

   always @(posedge CLK) begin
      if (mem_write && !mem_busywait) begin
         wflag[mem_address[5:0]] <= 1'b1;
         wdat[mem_address[5:0]]  <= mem_writedata;
      end
      cnt  <= (mreq != 2'b00 && mreq == last) ? cnt + 1 : 0;
      last <= mreq;
      if (mem_read || mem_write) memops <= memops + 1;
   end

   always @(negedge CLK) if (mem_read && mem_write) both_seen <= 1'b1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic wait_idle(input string nm, output int stall);
      stall = 0;
      while (busywait && stall < 200) begin
         @(negedge CLK); #1;
         stall++;
      end
      chk({nm, "_timeout"}, busywait, 1'b0);
   endtask

   task automatic wait_mem_read(input string nm);
      int n = 0;
      while (!mem_read && n < 200) begin
         @(negedge CLK); #1;
         n++;
      end
      chk({nm, "_mrd_timeout"}, mem_read, 1'b1);
   endtask

   task automatic drop_req();
      @(posedge CLK); #1;
      read = 1'b0; write = 1'b0;
   endtask

   typedef struct {
      logic        rd, wr;
      logic [31:0] addr, wdata, exp;
      logic        miss;
   } vec_t;
   vec_t tbl [12];

   task automatic run_vec(input int i);
      int    stall, m0;
      string nm;
      nm = $sformatf("vec%0d", i);
      m0 = memops;
      @(negedge CLK);
      read = tbl[i].rd; write = tbl[i].wr; address = tbl[i].addr; writedata = tbl[i].wdata;
      #1;
      chk({nm, "_busy"}, busywait, tbl[i].miss);
      wait_idle(nm, stall);
      if (tbl[i].rd && !tbl[i].wr) chk({nm, "_rdata"}, readdata, tbl[i].exp);
      drop_req();
      if (tbl[i].miss) chk({nm, "_stalled"}, stall > 0, 1'b1);
      else chk({nm, "_nomem"}, memops - m0, 0);
   endtask

   initial begin
      int stall;
      tbl[0]  = '{1'b1, 1'b0, 32'h0000004C, 32'h0,        32'h44444444, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 32'h00000044, 32'hDEADBEEF, 32'h0,        1'b0};
      tbl[2]  = '{1'b1, 1'b0, 32'h00000044, 32'h0,        32'hDEADBEEF, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 32'h00000040, 32'h0,        32'h11111111, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 32'h000000C8, 32'h0,        32'h2000000C, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 32'h00000048, 32'h0,        32'h33333333, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 32'h00000208, 32'hCAFEF00D, 32'h0,        1'b1};
      tbl[7]  = '{1'b1, 1'b0, 32'h00000208, 32'h0,        32'hCAFEF00D, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 32'h00000008, 32'h0,        32'h20000000, 1'b1};
      tbl[9]  = '{1'b1, 1'b0, 32'h00000208, 32'h0,        32'hCAFEF00D, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 32'h0000020C, 32'h12345678, 32'h0,        1'b0};
      tbl[11] = '{1'b1, 1'b0, 32'h0000020C, 32'h0,        32'h12345678, 1'b0};

      RESET = 1'b1; read = 1'b0; write = 1'b0; inst_hit = 1'b1;
      address = 32'h0; writedata = 32'h0;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
      #1;
      chk("rst_readdata", readdata, 32'h0);
      chk("rst_busy", busywait, 1'b0);
      chk("rst_mrd", mem_read, 1'b0);
      chk("rst_mwr", mem_write, 1'b0);
      chk("rst_maddr", mem_address, 28'h0);

      // clean fill of index 4
      @(negedge CLK);
      read = 1'b1; address = 32'h00000040; #1;
      chk("fill_busy", busywait, 1'b1);
      @(negedge CLK); #1;
      chk("fill_mrd", mem_read, 1'b1);
      chk("fill_mwr", mem_write, 1'b0);
      chk("fill_maddr", mem_address, 28'h0000004);
      wait_idle("fill", stall);
      chk("fill_rdata", readdata, 32'h11111111);
      drop_req();
      chk("fill_hold", readdata, 32'h11111111);

      for (int i = 0; i < 4; i++) run_vec(i);

      // dirty miss on index 4: write-back then refill
      @(negedge CLK);
      read = 1'b1; address = 32'h000000C4; #1;
      chk("wb_busy", busywait, 1'b1);
      @(negedge CLK); #1;
      chk("wb_mwr", mem_write, 1'b1);
      chk("wb_mrd", mem_read, 1'b0);
      chk("wb_maddr", mem_address, 28'h0000004);
      chk("wb_wdata", mem_writedata[63:32], 32'hDEADBEEF);
      wait_mem_read("wb");
      chk("wb_mr_maddr", mem_address, 28'h000000C);
      chk("wb_mr_mwr", mem_write, 1'b0);
      wait_idle("wb", stall);
      chk("wb_rdata", readdata, 32'h1000000C);
      drop_req();
      chk("wb_mem_block", wdat[4], 128'h44444444_33333333_DEADBEEF_11111111);

      for (int i = 4; i < 12; i++) run_vec(i);

      // inst_hit low suppresses a new miss; an accepted miss keeps going without it
      @(negedge CLK);
      inst_hit = 1'b0; read = 1'b1; address = 32'h00000110;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("ih_busy%0d", c), busywait, 1'b0);
         chk($sformatf("ih_mrd%0d", c), mem_read, 1'b0);
         @(negedge CLK);
      end
      chk("ih_hold", readdata, 32'h12345678);
      inst_hit = 1'b1; #1;
      chk("ih_busy_on", busywait, 1'b1);
      @(negedge CLK); #1;
      chk("ih_mrd_on", mem_read, 1'b1);
      chk("ih_maddr", mem_address, 28'h0000011);
      inst_hit = 1'b0;
      begin
         int n = 0;
         while (mem_read && n < 200) begin @(negedge CLK); #1; n++; end
         chk("ih_mrd_done", mem_read, 1'b0);
      end
      chk("ih_still_busy", busywait, 1'b1);
      inst_hit = 1'b1;
      wait_idle("ih", stall);
      chk("ih_rdata", readdata, 32'h00000011);
      drop_req();

      // reset in the middle of a refill
      @(negedge CLK);
      read = 1'b1; address = 32'h00000190;
      wait_mem_read("rm");
      RESET = 1'b1; #1;
      chk("rm_mrd", mem_read, 1'b0);
      chk("rm_busy", busywait, 1'b0);
      chk("rm_rdata", readdata, 32'h0);
      @(negedge CLK);
      RESET = 1'b0; #1;
      chk("rm_remiss", busywait, 1'b1);
      @(negedge CLK); #1;
      chk("rm_mrd_again", mem_read, 1'b1);
      chk("rm_maddr", mem_address, 28'h0000019);
      wait_idle("rm", stall);
      chk("rm_rdata_fill", readdata, 32'h00000019);
      drop_req();

      chk("never_both", both_seen, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
